rca_wide_add_seq: RTL
=====================

// Module: rca_wide_add_seq
// PURPOSE
//  Multi-cycle sequencer that adds WIDTH-bit operands by time-multiplexing a single 4-bit RCA
//  slice (ports a,b,cin,s,cout), one nibble per clock, LSB nibble first, carry held in a register.
//  Sits between an operand producer and a result consumer; valid/ready handshake on both sides.
//  Trades latency for area: one 4-bit ripple adder serves any WIDTH.
// PARAMETERS
//  WIDTH   16   operand/result width in bits; must be a multiple of 4 and >= 4
//  NSLICE  WIDTH/4  derived localparam, number of nibble passes; not overridable
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      synchronous reset, active low
//  in_valid   in   1      operand set offered
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  addend A
//  b          in   WIDTH  addend B
//  cin        in   1      carry into nibble 0
//  out_valid  out  1      result s/cout valid
//  out_ready  in   1      consumer takes result
//  s          out  WIDTH  sum
//  cout       out  1      carry out of the top nibble
// BEHAVIOUR
//  - One clock; reset synchronous, active-low, sampled on rising clk. rst_n low at an edge ->
//    state=IDLE, slice index=0, carry reg=0, s=0, cout=0, out_valid=0. in_ready=1 from the first
//    edge after rst_n is released. Handshake inputs during reset are ignored.
//  - FSM: IDLE -> RUN on in_valid&&in_ready; RUN -> DONE after nibble NSLICE-1 is processed;
//    DONE -> IDLE on out_valid&&out_ready. No other transitions except reset.
//  - IDLE: in_ready=1. On accept, latch a,b into operand regs, carry reg<=cin, idx<=0, s<=0.
//  - RUN: RCA slice inputs = a_reg[4*idx+:4], b_reg[4*idx+:4], carry reg. At each edge:
//    s[4*idx+:4]<=slice s, carry<=slice cout, idx<=idx+1. The edge that processes idx==NSLICE-1
//    also sets cout<=slice cout, out_valid<=1, state<=DONE. idx never wraps past NSLICE-1.
//  - Latency: out_valid rises exactly NSLICE rising edges after the accept edge (4 for WIDTH=16).
//  - DONE: s, cout, out_valid held stable until out_ready; in_ready=0. On out_valid&&out_ready
//    out_valid<=0 and state<=IDLE; next operand accepted no earlier than the following edge.
//  - Arithmetic: {cout,s} == a + b + cin modulo 2^(WIDTH+1); no truncation of the final carry.
//  - Changes on a/b/cin while in RUN/DONE have no effect (latched copies used).
//  - rst_n low in RUN or DONE: operation discarded, no out_valid pulse, state=IDLE.
//  - WIDTH not a multiple of 4, or < 4: elaboration fails ($error in generate block).
// CONFIGURATION
//  RCA_SEQ_SUB_EN defined: extra input port op (1 bit), sampled at accept. op=1 -> latch ~b
//    into b_reg and force carry reg<=1 (cin ignored); result s = a - b modulo 2^WIDTH,
//    cout = 1 when no borrow (a >= b unsigned). op=0 -> add as above.
//  RCA_SEQ_SUB_EN undefined: no op port; add only. Timing identical in both builds.
// TESTING
//  - Reset: hold rst_n=0 3 cycles, release -> s=0, cout=0, out_valid=0, in_ready=1.
//  - a=16'hFFFF, b=16'h0001, cin=0, out_ready=1 -> 4 edges after accept s=16'h0000, cout=1.
//  - a=16'h1234, b=16'h4321, cin=1 -> s=16'h5556, cout=0; in_ready=0 from accept to DONE exit.
//  - Backpressure: out_ready=0 for 5 cycles after out_valid -> s/cout/out_valid stable; a new
//    in_valid is not accepted; release -> IDLE, next op accepted one edge later.
//  - Reset mid-run: assert rst_n=0 on 2nd RUN edge -> no out_valid, in_ready=1 after release.
//  - RCA_SEQ_SUB_EN: op=1, a=16'h0005, b=16'h0007 -> s=16'hFFFE, cout=0; a=7,b=5 -> s=2, cout=1.
//    Plus full 256x256 sweep of low bytes (upper bytes 0 and FF) vs a+b+cin reference model.

Source files
------------

// File: rtl/rca_wide_add_seq.sv
// rca_wide_add_seq: WIDTH-bit adder that reuses one 4-bit ripple-carry slice, one nibble per clock
// Ports:
//   clk, rst_n            clock (rising edge) and synchronous active-low reset
//   in_valid / in_ready   operand handshake; in_ready is high only while idle
//   a, b, cin             operands, latched on accept
//   op                    present only with RCA_SEQ_SUB_EN defined: 1 = a - b, 0 = a + b + cin
//   out_valid / out_ready result handshake
//   s, cout               sum and final carry, held until the result is taken
// Optional feature macro: RCA_SEQ_SUB_EN
module rca_wide_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  if (WIDTH % 4 != 0 || WIDTH < 4) begin : g_bad_width
    $error("rca_wide_add_seq: WIDTH must be a multiple of 4 and >= 4");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [IW-1:0] idx_q, idx_d;
  logic c_q, c_d, cout_q, cout_d, ov_q, ov_d;
  logic sub, last;
  logic [3:0] sl_a, sl_b, sl_s;
  logic c1, c2, c3, c4;
`ifdef RCA_SEQ_SUB_EN
  assign sub = op;
`else
  assign sub = 1'b0;
`endif
  // The single shared 4-bit ripple slice, fed from the nibble selected by idx_q.
  assign sl_a = a_q[{idx_q, 2'b00} +: 4];
  assign sl_b = b_q[{idx_q, 2'b00} +: 4];
  assign sl_s[0] = sl_a[0] ^ sl_b[0] ^ c_q;
  assign c1 = (sl_a[0] & sl_b[0]) | (c_q & (sl_a[0] ^ sl_b[0]));
  assign sl_s[1] = sl_a[1] ^ sl_b[1] ^ c1;
  assign c2 = (sl_a[1] & sl_b[1]) | (c1 & (sl_a[1] ^ sl_b[1]));
  assign sl_s[2] = sl_a[2] ^ sl_b[2] ^ c2;
  assign c3 = (sl_a[2] & sl_b[2]) | (c2 & (sl_a[2] ^ sl_b[2]));
  assign sl_s[3] = sl_a[3] ^ sl_b[3] ^ c3;
  assign c4 = (sl_a[3] & sl_b[3]) | (c3 & (sl_a[3] ^ sl_b[3]));
  assign last = idx_q == IW'(NSLICE - 1);
  assign in_ready = rst_n && state_q == IDLE;
  assign out_valid = ov_q;
  assign s = s_q;
  assign cout = cout_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    idx_d = idx_q;
    s_d = s_q;
    cout_d = cout_q;
    ov_d = ov_q;
    if (state_q == IDLE) begin
      if (in_valid) begin
        state_d = RUN;
        a_d = a;
        // Subtraction is a + ~b + 1, so the slice itself never changes.
        b_d = sub ? ~b : b;
        c_d = sub ? 1'b1 : cin;
        idx_d = '0;
        s_d = '0;
      end
    end else if (state_q == RUN) begin
      s_d[{idx_q, 2'b00} +: 4] = sl_s;
      c_d = c4;
      idx_d = last ? idx_q : idx_q + 1'b1;
      if (last) begin
        cout_d = c4;
        ov_d = 1'b1;
        state_d = DONE;
      end
    end else if (state_q == DONE && out_ready) begin
      ov_d = 1'b0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      c_q <= 1'b0;
      idx_q <= '0;
      s_q <= '0;
      cout_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      idx_q <= idx_d;
      s_q <= s_d;
      cout_q <= cout_d;
      ov_q <= ov_d;
    end
  end
endmodule
